sm_dmem_responder: RTL and testbench
====================================

Name: sm_dmem_responder

Overview:
Data-memory-side responder for the schoolMIPS pipelined core's dm* bus. It owns word RAM plus a memory-mapped I/O window with a GPIO port and a compare timer. It answers core loads combinationally in the same cycle (M stage) and commits stores on the clock edge. It sits in the top-level beside the instruction ROM, wired directly to the core's dmAddr/dmWe/dmWData/dmRData.

Parameters:
RAM_AW, 6, log2 of RAM depth in 32-bit words (64 words).
GPIO_W, 8, width of GPIO input and output ports.

Ports:
clk  in  1  system clock, all state updates on posedge.
rst  in  1  reset, asynchronous, active-high.
dmAddr  in  32  byte address from core; bits [1:0] ignored.
dmWe  in  1  store strobe; write committed at posedge when high.
dmWData  in  32  store data.
dmRData  out  32  load data, combinational from dmAddr and current state.
gpioIn  in  GPIO_W  external inputs, asynchronous to clk.
gpioOut  out  GPIO_W  registered GPIO outputs.
tmrIrq  out  1  timer interrupt level = match & ctrl.irqEn.

Behaviour:
- Decode by address:
  - RAM: dmAddr[31:28]==4'h0; word index dmAddr[RAM_AW+1:2]; upper index bits alias.
  - IO: dmAddr[31:28]==4'h1, offset dmAddr[7:0]:
    - 0x00 GPIO_OUT (RW)
    - 0x04 GPIO_IN (RO)
    - 0x08 TMR_CNT (RW)
    - 0x0C TMR_CMP (RW)
    - 0x10 STATUS (bit0 match, write-1-to-clear)
    - 0x14 CTRL (bit0 run, bit1 autoReload, bit2 irqEn)
  - Anything else: read 0, write ignored.
- Reads: zero-latency combinational; narrow registers are zero-extended to 32 bits. A read and a write to the same address in one cycle returns the old value.
- Writes: take effect at posedge; a read in the following cycle sees the new value.
- RAM: not reset, contents X after power-up. No byte enables; full-word writes only.
- GPIO_IN: 2-flop synchronizer reset to 0, so pin changes are visible after 2 clk edges. Writes to GPIO_IN are ignored.
- Timer state machine, states IDLE (run=0) and RUN (run=1):
  - RUN: TMR_CNT increments by 1 each cycle, 32-bit wrap 0xFFFFFFFF->0.
  - When TMR_CNT==TMR_CMP in RUN, match sets sticky.
  - Same cycle, with autoReload=1, the next TMR_CNT is 0 instead of CMP+1.
  - IDLE: TMR_CNT holds its value.
- Simultaneous events:
  - CPU write to TMR_CNT beats increment and reload.
  - A match set in the same cycle as a W1C to STATUS wins, so match stays 1.
  - A write to CTRL.run takes effect from the next cycle.
- Reset mid-operation: async clear of gpioOut, sync flops, TMR_CNT, TMR_CMP, STATUS and CTRL to 0; tmrIrq falls to 0 immediately. RAM is untouched.
- Reset values of outputs: gpioOut=0, tmrIrq=0, dmRData follows decode (reads of the IO window return 0).

Optional Feature:
SM_DMEM_TIMER_EN.
- Defined: timer registers, STATUS, CTRL and tmrIrq behave as above.
- Undefined: offsets 0x08–0x14 read 0 and ignore writes; tmrIrq is tied to 0; no timer flops are synthesized.

Decomposition:
- Shared header sm_dmem.vh holds the constants: SM_DMEM_RAM_SEL (4'h0), SM_DMEM_IO_SEL (4'h1), offsets SM_DMEM_GPIO_OUT, SM_DMEM_GPIO_IN, SM_DMEM_TMR_CNT, SM_DMEM_TMR_CMP, SM_DMEM_STATUS, SM_DMEM_CTRL, and CTRL bit indices.
- One sub-module, sm_dmem_timer: count/compare/status/ctrl registers with write-strobe inputs and a read mux output. It is instantiated only under SM_DMEM_TIMER_EN.

Test Plan:
1. RAM round trip: store 0xDEADBEEF to 0x00000010, then load 0x00000010 the next cycle -> dmRData=0xDEADBEEF. A load of 0x00000013 (low bits ignored) -> same value. Same-cycle load during the store -> old contents.
2. GPIO: write 0xA5 to 0x10000000 -> gpioOut=0xA5 after the edge. Drive gpioIn=0x3C -> load of 0x10000004 returns 0x0000003C from the 2nd edge onward and 0 before it. A write to 0x10000004 changes nothing.
3. Timer auto-reload: CMP=3, CTRL=0x7 -> TMR_CNT sequence 0,1,2,3,0,1 with STATUS.match=1 and tmrIrq=1 from the edge after CNT==3. W1C of STATUS clears it until the next match.
4. Collisions: while running, write CNT=100 -> next read is 100, not 101. Issue W1C on STATUS in the same cycle CNT==CMP -> match stays 1.
5. Reset mid-run: assert rst asynchronously between edges while CNT=5 and gpioOut=0xFF -> gpioOut, tmrIrq and CNT read 0 immediately. A RAM word written earlier still reads back its value after rst deasserts.
6. Unmapped/feature-off: load 0x20000000 -> 0; store there -> no state change. With SM_DMEM_TIMER_EN undefined, load 0x10000008 -> 0 and tmrIrq stays 0 under CTRL=0x7 writes.

Source files
------------

// File: rtl/sm_dmem_responder_pkg.sv
// sm_dmem_responder_pkg: shared constants and types for the schoolMIPS data-memory responder.
//   Address-region selects (dmAddr[31:28]), I/O register byte offsets (dmAddr[7:0]),
//   CTRL bit indices and the timer state type.
//   No ports (package).
package sm_dmem_responder_pkg;

    localparam logic [3:0] SM_DMEM_RAM_SEL = 4'h0;
    localparam logic [3:0] SM_DMEM_IO_SEL  = 4'h1;

    localparam logic [7:0] SM_DMEM_GPIO_OUT = 8'h00;
    localparam logic [7:0] SM_DMEM_GPIO_IN  = 8'h04;
    localparam logic [7:0] SM_DMEM_TMR_CNT  = 8'h08;
    localparam logic [7:0] SM_DMEM_TMR_CMP  = 8'h0C;
    localparam logic [7:0] SM_DMEM_STATUS   = 8'h10;
    localparam logic [7:0] SM_DMEM_CTRL     = 8'h14;

    localparam int unsigned SM_DMEM_CTRL_RUN    = 0;
    localparam int unsigned SM_DMEM_CTRL_RELOAD = 1;
    localparam int unsigned SM_DMEM_CTRL_IRQEN  = 2;

    typedef enum logic {TmrIdle, TmrRun} tmrState_e;

endpackage

// File: rtl/sm_dmem_timer.sv
// sm_dmem_timer: compare timer with sticky match status and control register.
//   Built only when SM_DMEM_TIMER_EN is defined.
//   clk, rst        : clock, asynchronous active-high reset
//   cntWe..ctrlWe   : per-register write strobes, committed at posedge
//   wData           : store data
//   rdWord          : register word offset (byte offset [7:2]) for the read mux
//   rData           : read data, zero for offsets that are not timer registers
//   irq             : match & irqEn
`ifdef SM_DMEM_TIMER_EN
module sm_dmem_timer
    import sm_dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cntWe,
    input  logic        cmpWe,
    input  logic        statusWe,
    input  logic        ctrlWe,
    input  logic [31:0] wData,
    input  logic [5:0]  rdWord,
    output logic [31:0] rData,
    output logic        irq
);

    tmrState_e   state;
    logic [31:0] cnt;
    logic [31:0] cmp;
    logic        match;
    logic        autoReload;
    logic        irqEn;
    logic        hit;

    assign hit = (state == TmrRun) && (cnt == cmp);

    // Priorities: CPU write to CNT beats increment/reload; a hit beats a W1C of STATUS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= TmrIdle;
            cnt        <= '0;
            cmp        <= '0;
            match      <= 1'b0;
            autoReload <= 1'b0;
            irqEn      <= 1'b0;
        end else begin
            if (cntWe)                cnt <= wData;
            else if (state == TmrRun) cnt <= (hit && autoReload) ? 32'd0 : cnt + 32'd1;

            if (cmpWe) cmp <= wData;

            if (hit)                       match <= 1'b1;
            else if (statusWe && wData[0]) match <= 1'b0;

            if (ctrlWe) begin
                state      <= wData[SM_DMEM_CTRL_RUN] ? TmrRun : TmrIdle;
                autoReload <= wData[SM_DMEM_CTRL_RELOAD];
                irqEn      <= wData[SM_DMEM_CTRL_IRQEN];
            end
        end
    end

    always_comb begin
        rData = '0;
        if (rdWord == SM_DMEM_TMR_CNT[7:2])      rData = cnt;
        else if (rdWord == SM_DMEM_TMR_CMP[7:2]) rData = cmp;
        else if (rdWord == SM_DMEM_STATUS[7:2])  rData = {31'd0, match};
        else if (rdWord == SM_DMEM_CTRL[7:2])    rData = {29'd0, irqEn, autoReload, state == TmrRun};
    end

    assign irq = match & irqEn;

endmodule
`endif

// File: rtl/sm_dmem_responder.sv
// sm_dmem_responder: schoolMIPS dm* bus responder (word RAM + GPIO + optional timer).
//   Optional timer enabled by defining SM_DMEM_TIMER_EN; otherwise offsets 0x08-0x14
//   read 0, ignore writes and tmrIrq is tied low.
//   clk, rst : clock, asynchronous active-high reset
//   dmAddr   : byte address, bits [1:0] ignored
//   dmWe     : store strobe, committed at posedge
//   dmWData  : store data
//   dmRData  : combinational load data
//   gpioIn   : asynchronous GPIO inputs (2-flop synchronized)
//   gpioOut  : registered GPIO outputs
//   tmrIrq   : timer interrupt level
module sm_dmem_responder
    import sm_dmem_responder_pkg::*;
#(
    parameter int unsigned RAM_AW = 6,
    parameter int unsigned GPIO_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dmAddr,
    input  logic              dmWe,
    input  logic [31:0]       dmWData,
    output logic [31:0]       dmRData,
    input  logic [GPIO_W-1:0] gpioIn,
    output logic [GPIO_W-1:0] gpioOut,
    output logic              tmrIrq
);

    logic              ramSel;
    logic              ioSel;
    logic [5:0]        ioWord;
    logic [RAM_AW-1:0] ramIdx;
    logic [31:0]       ram [0:(1 << RAM_AW) - 1];
    logic [GPIO_W-1:0] gpioMeta;
    logic [GPIO_W-1:0] gpioSync;
    logic [31:0]       tmrRData;
    logic              unusedAddrBits;

    assign ramSel = (dmAddr[31:28] == SM_DMEM_RAM_SEL);
    assign ioSel  = (dmAddr[31:28] == SM_DMEM_IO_SEL);
    assign ioWord = dmAddr[7:2];
    assign ramIdx = dmAddr[RAM_AW+1:2];
    // Upper RAM index bits alias; I/O decodes only the low byte.
    assign unusedAddrBits = ^{dmAddr[27:8], dmAddr[1:0]};

    // RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (dmWe && ramSel) ram[ramIdx] <= dmWData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpioOut  <= '0;
            gpioMeta <= '0;
            gpioSync <= '0;
        end else begin
            gpioMeta <= gpioIn;
            gpioSync <= gpioMeta;
            if (dmWe && ioSel && ioWord == SM_DMEM_GPIO_OUT[7:2]) gpioOut <= dmWData[GPIO_W-1:0];
        end
    end

`ifdef SM_DMEM_TIMER_EN
    logic tmrWe;
    assign tmrWe = dmWe & ioSel;

    sm_dmem_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .cntWe    (tmrWe && ioWord == SM_DMEM_TMR_CNT[7:2]),
        .cmpWe    (tmrWe && ioWord == SM_DMEM_TMR_CMP[7:2]),
        .statusWe (tmrWe && ioWord == SM_DMEM_STATUS[7:2]),
        .ctrlWe   (tmrWe && ioWord == SM_DMEM_CTRL[7:2]),
        .wData    (dmWData),
        .rdWord   (ioWord),
        .rData    (tmrRData),
        .irq      (tmrIrq)
    );
`else
    assign tmrRData = '0;
    assign tmrIrq   = 1'b0;
`endif

    always_comb begin
        dmRData = '0;
        if (ramSel) begin
            dmRData = ram[ramIdx];
        end else if (ioSel) begin
            if (ioWord == SM_DMEM_GPIO_OUT[7:2])     dmRData = 32'(gpioOut);
            else if (ioWord == SM_DMEM_GPIO_IN[7:2]) dmRData = 32'(gpioSync);
            else                                     dmRData = tmrRData;
        end
    end

endmodule

// File: tb/tb_sm_dmem_responder.sv
// tb_sm_dmem_responder: directed self-checking bench for sm_dmem_responder.
//   Timer checks run when SM_DMEM_TIMER_EN is defined; feature-off checks otherwise.
module tb_sm_dmem_responder;

    localparam logic [31:0] A_GPIO_OUT = 32'h1000_0000;
    localparam logic [31:0] A_GPIO_IN  = 32'h1000_0004;
    localparam logic [31:0] A_CNT      = 32'h1000_0008;
    localparam logic [31:0] A_CMP      = 32'h1000_000C;
    localparam logic [31:0] A_STATUS   = 32'h1000_0010;
    localparam logic [31:0] A_CTRL     = 32'h1000_0014;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dmAddr = '0;
    logic        dmWe = 1'b0;
    logic [31:0] dmWData = '0;
    logic [31:0] dmRData;
    logic [7:0]  gpioIn = '0;
    logic [7:0]  gpioOut;
    logic        tmrIrq;

    int total = 0;
    int bad = 0;

    sm_dmem_responder dut (
        .clk     (clk),
        .rst     (rst),
        .dmAddr  (dmAddr),
        .dmWe    (dmWe),
        .dmWData (dmWData),
        .dmRData (dmRData),
        .gpioIn  (gpioIn),
        .gpioOut (gpioOut),
        .tmrIrq  (tmrIrq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
        dmAddr  = a;
        dmWe    = we;
        dmWData = d;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(a, 1'b1, d);
        tick;
        dmWe = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        tick;
        drive(A_GPIO_OUT, 1'b0, '0);
        total++;
        if (gpioOut !== 8'h00) begin bad++; $display("FAIL rst_gpioOut got=%h exp=00", gpioOut); end
        total++;
        if (tmrIrq !== 1'b0) begin bad++; $display("FAIL rst_tmrIrq got=%b exp=0", tmrIrq); end
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL rst_rd_gpio_out got=%h exp=0", dmRData); end
        drive(A_CTRL, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL rst_rd_ctrl got=%h exp=0", dmRData); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_ram;
        wr(32'h0000_0010, 32'h1111_1111);
        wr(32'h0000_0014, 32'h2222_2222);
        drive(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        total++;
        if (dmRData !== 32'h1111_1111) begin bad++; $display("FAIL ram_same_cycle got=%h exp=11111111", dmRData); end
        tick;
        drive(32'h0000_0010, 1'b0, '0);
        total++;
        if (dmRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd got=%h exp=deadbeef", dmRData); end
        drive(32'h0000_0013, 1'b0, '0);
        total++;
        if (dmRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_lowbits got=%h exp=deadbeef", dmRData); end
        drive(32'h0000_0110, 1'b0, '0);
        total++;
        if (dmRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_alias got=%h exp=deadbeef", dmRData); end
        drive(32'h0000_0014, 1'b0, '0);
        total++;
        if (dmRData !== 32'h2222_2222) begin bad++; $display("FAIL ram_neighbour got=%h exp=22222222", dmRData); end
    endtask

    task automatic test_gpio;
        drive(A_GPIO_OUT, 1'b1, 32'h0000_00A5);
        total++;
        if (gpioOut !== 8'h00) begin bad++; $display("FAIL gpio_pre_edge got=%h exp=00", gpioOut); end
        tick;
        dmWe = 1'b0;
        #1;
        total++;
        if (gpioOut !== 8'hA5) begin bad++; $display("FAIL gpio_out got=%h exp=a5", gpioOut); end
        total++;
        if (dmRData !== 32'h0000_00A5) begin bad++; $display("FAIL gpio_out_rd got=%h exp=a5", dmRData); end
        gpioIn = 8'h3C;
        drive(A_GPIO_IN, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL gpio_in_edge0 got=%h exp=0", dmRData); end
        tick;
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL gpio_in_edge1 got=%h exp=0", dmRData); end
        tick;
        total++;
        if (dmRData !== 32'h0000_003C) begin bad++; $display("FAIL gpio_in_edge2 got=%h exp=3c", dmRData); end
        wr(A_GPIO_IN, 32'hFFFF_FFFF);
        drive(A_GPIO_IN, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0000_003C) begin bad++; $display("FAIL gpio_in_ro got=%h exp=3c", dmRData); end
        total++;
        if (gpioOut !== 8'hA5) begin bad++; $display("FAIL gpio_in_wr_side got=%h exp=a5", gpioOut); end
    endtask

    task automatic test_unmapped;
        wr(32'h0000_0000, 32'h1234_5678);
        drive(32'h2000_0000, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", dmRData); end
        wr(32'h2000_0000, 32'hCAFE_F00D);
        wr(32'h1000_0018, 32'hCAFE_F00D);
        drive(32'h0000_0000, 1'b0, '0);
        total++;
        if (dmRData !== 32'h1234_5678) begin bad++; $display("FAIL unmapped_wr_ram got=%h exp=12345678", dmRData); end
        drive(32'h1000_0018, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL io_hole_rd got=%h exp=0", dmRData); end
        total++;
        if (gpioOut !== 8'hA5) begin bad++; $display("FAIL unmapped_wr_gpio got=%h exp=a5", gpioOut); end
    endtask

`ifdef SM_DMEM_TIMER_EN
    task automatic test_timer_reload;
        logic [31:0] expCnt [6];
        logic        expIrq [6];
        expCnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        expIrq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        wr(A_CMP, 32'd3);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h7);
        for (int i = 0; i < 6; i++) begin
            drive(A_CNT, 1'b0, '0);
            total++;
            if (dmRData !== expCnt[i]) begin bad++; $display("FAIL reload_cnt[%0d] got=%h exp=%h", i, dmRData, expCnt[i]); end
            total++;
            if (tmrIrq !== expIrq[i]) begin bad++; $display("FAIL reload_irq[%0d] got=%b exp=%b", i, tmrIrq, expIrq[i]); end
            tick;
        end
        // CNT is 2 here; W1C reads back the old sticky value in the same cycle.
        drive(A_STATUS, 1'b1, 32'h1);
        total++;
        if (dmRData !== 32'h1) begin bad++; $display("FAIL status_set got=%h exp=1", dmRData); end
        tick;
        drive(A_STATUS, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL status_w1c got=%h exp=0", dmRData); end
        total++;
        if (tmrIrq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b exp=0", tmrIrq); end
        tick;
        total++;
        if (dmRData !== 32'h1) begin bad++; $display("FAIL status_rematch got=%h exp=1", dmRData); end
        total++;
        if (tmrIrq !== 1'b1) begin bad++; $display("FAIL irq_rematch got=%b exp=1", tmrIrq); end
    endtask

    task automatic test_collisions;
        wr(A_CNT, 32'd100);
        drive(A_CNT, 1'b0, '0);
        total++;
        if (dmRData !== 32'd100) begin bad++; $display("FAIL cnt_wr_wins got=%0d exp=100", dmRData); end
        tick;
        total++;
        if (dmRData !== 32'd101) begin bad++; $display("FAIL cnt_after_wr got=%0d exp=101", dmRData); end
        wr(A_CNT, 32'd2);
        drive(A_STATUS, 1'b1, 32'h1);
        tick;
        // CNT==CMP this cycle and a W1C is pending again.
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL status_cleared got=%h exp=0", dmRData); end
        tick;
        drive(A_STATUS, 1'b0, '0);
        total++;
        if (dmRData !== 32'h1) begin bad++; $display("FAIL match_beats_w1c got=%h exp=1", dmRData); end
        total++;
        if (tmrIrq !== 1'b1) begin bad++; $display("FAIL irq_match_beats_w1c got=%b exp=1", tmrIrq); end
    endtask
`else
    task automatic test_timer_off;
        wr(A_CMP, 32'd3);
        wr(A_CNT, 32'h55);
        wr(A_CTRL, 32'h7);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (tmrIrq !== 1'b0) begin bad++; $display("FAIL off_irq[%0d] got=%b exp=0", i, tmrIrq); end
            tick;
        end
        drive(A_CNT, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL off_cnt got=%h exp=0", dmRData); end
        drive(A_CMP, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL off_cmp got=%h exp=0", dmRData); end
        drive(A_STATUS, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL off_status got=%h exp=0", dmRData); end
        drive(A_CTRL, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL off_ctrl got=%h exp=0", dmRData); end
    endtask
`endif

    task automatic test_reset_mid;
        wr(A_GPIO_OUT, 32'hFF);
        wr(32'h0000_0020, 32'h0BAD_F00D);
`ifdef SM_DMEM_TIMER_EN
        wr(A_CNT, 32'd4);
        tick;
        drive(A_CNT, 1'b0, '0);
        total++;
        if (dmRData !== 32'd5) begin bad++; $display("FAIL pre_rst_cnt got=%0d exp=5", dmRData); end
        total++;
        if (tmrIrq !== 1'b1) begin bad++; $display("FAIL pre_rst_irq got=%b exp=1", tmrIrq); end
`else
        drive(A_GPIO_OUT, 1'b0, '0);
        total++;
        if (dmRData !== 32'hFF) begin bad++; $display("FAIL pre_rst_gpio got=%h exp=ff", dmRData); end
`endif
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (gpioOut !== 8'h00) begin bad++; $display("FAIL mid_rst_gpioOut got=%h exp=00", gpioOut); end
        total++;
        if (tmrIrq !== 1'b0) begin bad++; $display("FAIL mid_rst_irq got=%b exp=0", tmrIrq); end
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL mid_rst_rd got=%h exp=0", dmRData); end
        drive(A_GPIO_IN, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL mid_rst_sync got=%h exp=0", dmRData); end
        tick;
        rst = 1'b0;
        drive(32'h0000_0020, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0BAD_F00D) begin bad++; $display("FAIL ram_kept got=%h exp=0badf00d", dmRData); end
        drive(32'h0000_0010, 1'b0, '0);
        total++;
        if (dmRData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_kept2 got=%h exp=deadbeef", dmRData); end
        drive(A_CTRL, 1'b0, '0);
        total++;
        if (dmRData !== 32'h0) begin bad++; $display("FAIL post_rst_ctrl got=%h exp=0", dmRData); end
    endtask

    initial begin
        test_reset;
        test_ram;
        test_gpio;
        test_unmapped;
`ifdef SM_DMEM_TIMER_EN
        test_timer_reload;
        test_collisions;
`else
        test_timer_off;
`endif
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
